// File: rtl/spi_mem_arbiter.sv
// Quad-SPI bus sequencer shared by the flash (instruction fetch) and RAM A (data port).
// Runs one byte-sized transaction at a time and round-robins only when both ports request together.
module spi_mem_arbiter #(
  parameter int          DATA_BUS_WIDTH = 8,
  parameter int          ADDRESS_WIDTH  = 16,
  parameter logic [7:0]  FLASH_READ_CMD = 8'hEB,
  parameter logic [7:0]  RAM_READ_CMD   = 8'hEB,
  parameter logic [7:0]  RAM_WRITE_CMD  = 8'h38,
  parameter int          READ_DUMMY     = 6
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      fetch_req,
  input  logic [ADDRESS_WIDTH-1:0]  fetch_addr,
  output logic [DATA_BUS_WIDTH-1:0] fetch_rdata,
  output logic                      fetch_ack,
  input  logic                      mem_req,
  input  logic                      mem_we,
  input  logic [ADDRESS_WIDTH-1:0]  mem_addr,
  input  logic [DATA_BUS_WIDTH-1:0] mem_wdata,
  output logic [DATA_BUS_WIDTH-1:0] mem_rdata,
  output logic                      mem_ack,
  input  logic [3:0]                spi_data_in,
  output logic [3:0]                spi_data_out,
  output logic [3:0]                spi_data_oe,
  output logic                      spi_clk_out,
  output logic                      spi_flash_select,
  output logic                      spi_ram_a_select,
  output logic                      busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DONE
  } state_e;

  // Phase lengths in system clocks; every SPI cycle is an L clock followed by an H clock.
  localparam logic [4:0] CMD_LAST   = 5'd3;
  localparam logic [4:0] ADDR_LAST  = 5'd11;
  localparam logic [4:0] DUMMY_LAST = 5'(2 * READ_DUMMY - 1);
  localparam logic [4:0] DATA_LAST  = 5'd3;

  state_e                      state_q, state_d;
  logic [4:0]                  cnt_q, cnt_d;
  logic                        grant_mem_q, grant_mem_d;
  logic                        last_grant_mem_q, last_grant_mem_d;
  logic                        we_q, we_d;
  logic [ADDRESS_WIDTH-1:0]    addr_q, addr_d;
  logic [DATA_BUS_WIDTH-1:0]   wdata_q, wdata_d;
  logic [3:0]                  rd_hi_q, rd_hi_d;
  logic [DATA_BUS_WIDTH-1:0]   fetch_rdata_q, fetch_rdata_d;
  logic [DATA_BUS_WIDTH-1:0]   mem_rdata_q, mem_rdata_d;
  logic                        fetch_ack_q, fetch_ack_d;
  logic                        mem_ack_q, mem_ack_d;
  logic [3:0]                  spi_dout_q, spi_dout_d;
  logic [3:0]                  spi_oe_q, spi_oe_d;
  logic                        spi_clk_q, spi_clk_d;
  logic                        cs_flash_q, cs_flash_d;
  logic                        cs_ram_q, cs_ram_d;

  logic [7:0]                  cmd_byte;
  logic [23:0]                 addr24;
  logic [23:0]                 addr_sh;

  // State register plus all datapath and registered-output flops.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= S_IDLE;
      cnt_q            <= '0;
      grant_mem_q      <= 1'b0;
      last_grant_mem_q <= 1'b0;
      we_q             <= 1'b0;
      addr_q           <= '0;
      wdata_q          <= '0;
      rd_hi_q          <= '0;
      fetch_rdata_q    <= '0;
      mem_rdata_q      <= '0;
      fetch_ack_q      <= 1'b0;
      mem_ack_q        <= 1'b0;
      spi_dout_q       <= '0;
      spi_oe_q         <= '0;
      spi_clk_q        <= 1'b0;
      cs_flash_q       <= 1'b1;
      cs_ram_q         <= 1'b1;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      grant_mem_q      <= grant_mem_d;
      last_grant_mem_q <= last_grant_mem_d;
      we_q             <= we_d;
      addr_q           <= addr_d;
      wdata_q          <= wdata_d;
      rd_hi_q          <= rd_hi_d;
      fetch_rdata_q    <= fetch_rdata_d;
      mem_rdata_q      <= mem_rdata_d;
      fetch_ack_q      <= fetch_ack_d;
      mem_ack_q        <= mem_ack_d;
      spi_dout_q       <= spi_dout_d;
      spi_oe_q         <= spi_oe_d;
      spi_clk_q        <= spi_clk_d;
      cs_flash_q       <= cs_flash_d;
      cs_ram_q         <= cs_ram_d;
    end
  end

  // Next-state logic, arbitration and grant-time capture of the request.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q + 5'd1;
    grant_mem_d      = grant_mem_q;
    last_grant_mem_d = last_grant_mem_q;
    we_d             = we_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (fetch_req || mem_req) begin
          state_d = S_SETUP;
          // last_grant only moves on a tie, so a lone request never steals the next tie.
          if (fetch_req && mem_req) begin
            grant_mem_d      = !last_grant_mem_q;
            last_grant_mem_d = !last_grant_mem_q;
          end else begin
            grant_mem_d = mem_req;
          end
          if (grant_mem_d) begin
            we_d    = mem_we;
            addr_d  = mem_addr;
            wdata_d = mem_wdata;
          end else begin
            we_d    = 1'b0;
            addr_d  = fetch_addr;
            wdata_d = '0;
          end
        end
      end
      S_SETUP: begin
        state_d = S_CMD;
        cnt_d   = '0;
      end
      S_CMD: begin
        if (cnt_q == CMD_LAST) begin
          state_d = S_ADDR;
          cnt_d   = '0;
        end
      end
      S_ADDR: begin
        if (cnt_q == ADDR_LAST) begin
          state_d = we_q ? S_DATA : S_DUMMY;
          cnt_d   = '0;
        end
      end
      S_DUMMY: begin
        if (cnt_q == DUMMY_LAST) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end
      end
      S_DATA: begin
        if (cnt_q == DATA_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Read capture: nibbles land on the edge that ends each H clock of the data phase.
  always_comb begin
    rd_hi_d       = rd_hi_q;
    fetch_rdata_d = fetch_rdata_q;
    mem_rdata_d   = mem_rdata_q;
    if (state_q == S_DATA && !we_q) begin
      if (cnt_q == 5'd1) begin
        rd_hi_d = spi_data_in;
      end
      if (cnt_q == DATA_LAST) begin
        if (grant_mem_q) begin
          mem_rdata_d = {rd_hi_q, spi_data_in};
        end else begin
          fetch_rdata_d = {rd_hi_q, spi_data_in};
        end
      end
    end
  end

  assign cmd_byte = grant_mem_q ? (we_q ? RAM_WRITE_CMD : RAM_READ_CMD) : FLASH_READ_CMD;
  assign addr24   = 24'(addr_q);

  // Output values are computed from the upcoming state so every SPI pin is a flop.
  always_comb begin
    cs_flash_d  = 1'b1;
    cs_ram_d    = 1'b1;
    spi_clk_d   = 1'b0;
    spi_oe_d    = 4'h0;
    spi_dout_d  = 4'h0;
    fetch_ack_d = 1'b0;
    mem_ack_d   = 1'b0;
    addr_sh     = addr24 << {cnt_d[3:1], 2'b00};
    case (state_d)
      S_SETUP: begin
        cs_flash_d = grant_mem_d;
        cs_ram_d   = !grant_mem_d;
        spi_oe_d   = 4'hF;
      end
      S_CMD: begin
        cs_flash_d = grant_mem_q;
        cs_ram_d   = !grant_mem_q;
        spi_clk_d  = cnt_d[0];
        spi_oe_d   = 4'hF;
        spi_dout_d = cnt_d[1] ? cmd_byte[3:0] : cmd_byte[7:4];
      end
      S_ADDR: begin
        cs_flash_d = grant_mem_q;
        cs_ram_d   = !grant_mem_q;
        spi_clk_d  = cnt_d[0];
        spi_oe_d   = 4'hF;
        spi_dout_d = addr_sh[23:20];
      end
      S_DUMMY: begin
        cs_flash_d = grant_mem_q;
        cs_ram_d   = !grant_mem_q;
        spi_clk_d  = cnt_d[0];
      end
      S_DATA: begin
        cs_flash_d = grant_mem_q;
        cs_ram_d   = !grant_mem_q;
        spi_clk_d  = cnt_d[0];
        if (we_q) begin
          spi_oe_d   = 4'hF;
          spi_dout_d = cnt_d[1] ? wdata_q[3:0] : wdata_q[7:4];
        end
      end
      S_DONE: begin
        fetch_ack_d = !grant_mem_q;
        mem_ack_d   = grant_mem_q;
      end
      default: begin
        cs_flash_d = 1'b1;
        cs_ram_d   = 1'b1;
      end
    endcase
  end

  assign fetch_rdata      = fetch_rdata_q;
  assign fetch_ack        = fetch_ack_q;
  assign mem_rdata        = mem_rdata_q;
  assign mem_ack          = mem_ack_q;
  assign spi_data_out     = spi_dout_q;
  assign spi_data_oe      = spi_oe_q;
  assign spi_clk_out      = spi_clk_q;
  assign spi_flash_select = cs_flash_q;
  assign spi_ram_a_select = cs_ram_q;
  assign busy             = (state_q != S_IDLE);

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Directed bench for spi_mem_arbiter: quad-SPI slave model on the bus plus scoreboards for
// driven nibbles, SPI cycle counts and returned bytes.
module tb_spi_mem_arbiter;
  localparam int RD = 6;

  logic        clock = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic [7:0]  fetch_rdata;
  logic        fetch_ack;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic [3:0]  spi_data_in;
  logic [3:0]  spi_data_out;
  logic [3:0]  spi_data_oe;
  logic        spi_clk_out;
  logic        spi_flash_select;
  logic        spi_ram_a_select;
  logic        busy;

  spi_mem_arbiter #(.READ_DUMMY(RD)) dut (
    .clock(clock), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_rdata(fetch_rdata), .fetch_ack(fetch_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .spi_data_in(spi_data_in), .spi_data_out(spi_data_out), .spi_data_oe(spi_data_oe),
    .spi_clk_out(spi_clk_out), .spi_flash_select(spi_flash_select),
    .spi_ram_a_select(spi_ram_a_select), .busy(busy)
  );

  // Clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard state
  int         n_cmp = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         spi_cyc = 0;
  int         flash_low_cnt = 0;
  int         ram_low_cnt = 0;
  int         fetch_ack_cnt = 0;
  int         fetch_ack_cyc = 0;
  int         mem_ack_cyc = 0;
  bit         mon_check = 1'b1;
  bit         prev_cs_low = 1'b0;
  logic [7:0] slave_byte = 8'h00;
  logic [3:0] exp_q[$];
  int         exp_cyc_q[$];
  logic [7:0] slave_q[$];
  logic [7:0] exp_fetch_q[$];
  logic [7:0] exp_mem_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_txn(input logic [7:0] cmd, input logic [15:0] addr, input bit wr,
                          input logic [7:0] wd);
    logic [23:0] a;
    a = {8'h00, addr};
    exp_q.push_back(cmd[7:4]);
    exp_q.push_back(cmd[3:0]);
    for (int i = 5; i >= 0; i--) exp_q.push_back(a[i*4 +: 4]);
    if (wr) begin
      exp_q.push_back(wd[7:4]);
      exp_q.push_back(wd[3:0]);
      exp_cyc_q.push_back(10);
    end else begin
      exp_cyc_q.push_back(10 + RD);
    end
  endtask

  // One clock: sample at the falling edge, check bus rules, act as the SPI slave.
  task automatic step();
    int ec;
    @(negedge clock);
    cyc++;
    chk("clk_while_deselected", {31'd0, spi_clk_out & spi_flash_select & spi_ram_a_select}, 32'd0);
    chk("both_cs_low", {31'd0, ~spi_flash_select & ~spi_ram_a_select}, 32'd0);
    if (!spi_flash_select) flash_low_cnt++;
    if (!spi_ram_a_select) ram_low_cnt++;
    if (spi_flash_select && spi_ram_a_select) begin
      if (prev_cs_low && mon_check) begin
        ec = exp_cyc_q.size() > 0 ? exp_cyc_q.pop_front() : -1;
        chk("spi_cycle_count", spi_cyc, ec);
      end
      prev_cs_low = 1'b0;
      spi_cyc     = 0;
      spi_data_in = 4'h0;
    end else begin
      prev_cs_low = 1'b1;
      if (spi_clk_out) begin
        if (mon_check && spi_data_oe == 4'hF) begin
          chk("nibble_expected", {31'd0, exp_q.size() > 0}, 32'd1);
          if (exp_q.size() > 0) chk("nibble", {28'd0, spi_data_out}, {28'd0, exp_q.pop_front()});
        end
        if (spi_data_oe == 4'h0 && spi_cyc == 8 + RD) begin
          slave_byte  = slave_q.size() > 0 ? slave_q.pop_front() : 8'h00;
          spi_data_in = slave_byte[7:4];
        end else if (spi_data_oe == 4'h0 && spi_cyc == 9 + RD) begin
          spi_data_in = slave_byte[3:0];
        end else begin
          spi_data_in = 4'h0;
        end
        spi_cyc++;
      end
    end
    if (fetch_ack) begin
      fetch_ack_cnt++;
      fetch_ack_cyc = cyc;
    end
    if (mem_ack) mem_ack_cyc = cyc;
  endtask

  // Driver: step until the wanted acks arrive, dropping each req on its ack.
  task automatic run_until_acks(input bit want_f, input bit want_m, input int budget);
    bit got_f;
    bit got_m;
    int n;
    got_f = 1'b0;
    got_m = 1'b0;
    n = 0;
    while ((want_f && !got_f) || (want_m && !got_m)) begin
      if (n == budget) begin
        chk("ack_timeout", {30'd0, got_f, got_m}, {30'd0, want_f, want_m});
        break;
      end
      step();
      n++;
      if (fetch_ack) begin
        chk("fetch_ack_wanted", {31'd0, want_f && !got_f}, 32'd1);
        got_f = 1'b1;
        fetch_req = 1'b0;
        if (exp_fetch_q.size() > 0) chk("fetch_rdata", {24'd0, fetch_rdata}, {24'd0, exp_fetch_q.pop_front()});
      end
      if (mem_ack) begin
        chk("mem_ack_wanted", {31'd0, want_m && !got_m}, 32'd1);
        got_m = 1'b1;
        mem_req = 1'b0;
        if (!mem_we && exp_mem_q.size() > 0) chk("mem_rdata", {24'd0, mem_rdata}, {24'd0, exp_mem_q.pop_front()});
      end
    end
  endtask

  int t0;
  int f0;
  int r0;
  int a0;

  initial begin
    reset = 1'b1; fetch_req = 1'b0; fetch_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
    mem_addr = '0; mem_wdata = '0; spi_data_in = 4'h0;
    repeat (3) step();
    chk("rst_flash_cs", {31'd0, spi_flash_select}, 32'd1);
    chk("rst_ram_cs", {31'd0, spi_ram_a_select}, 32'd1);
    chk("rst_clk", {31'd0, spi_clk_out}, 32'd0);
    chk("rst_oe", {28'd0, spi_data_oe}, 32'd0);
    chk("rst_dout", {28'd0, spi_data_out}, 32'd0);
    chk("rst_acks", {30'd0, fetch_ack, mem_ack}, 32'd0);
    chk("rst_rdata", {16'd0, fetch_rdata, mem_rdata}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    step();

    // Flash fetch of 0x1234 returning 0xA5
    push_txn(8'hEB, 16'h1234, 1'b0, 8'h00);
    slave_q.push_back(8'hA5); exp_fetch_q.push_back(8'hA5);
    f0 = flash_low_cnt; r0 = ram_low_cnt;
    fetch_addr = 16'h1234; fetch_req = 1'b1; t0 = cyc;
    step();
    chk("setup_busy", {31'd0, busy}, 32'd1);
    chk("setup_flash_cs", {31'd0, spi_flash_select}, 32'd0);
    chk("setup_oe", {28'd0, spi_data_oe}, 32'hF);
    run_until_acks(1'b1, 1'b0, 60);
    chk("fetch_latency", fetch_ack_cyc - t0, 34);
    chk("fetch_flash_low", flash_low_cnt - f0, 33);
    chk("fetch_ram_low", ram_low_cnt - r0, 0);

    // RAM write 0x3C to 0x00FF
    step();
    push_txn(8'h38, 16'h00FF, 1'b1, 8'h3C);
    f0 = flash_low_cnt; r0 = ram_low_cnt;
    mem_we = 1'b1; mem_addr = 16'h00FF; mem_wdata = 8'h3C; mem_req = 1'b1; t0 = cyc;
    run_until_acks(1'b0, 1'b1, 60);
    chk("write_latency", mem_ack_cyc - t0, 22);
    chk("write_ram_low", ram_low_cnt - r0, 21);
    chk("write_flash_low", flash_low_cnt - f0, 0);

    // RAM read of 0x0010 returning 0x5A; fetch_rdata must keep 0xA5
    step();
    push_txn(8'hEB, 16'h0010, 1'b0, 8'h00);
    slave_q.push_back(8'h5A); exp_mem_q.push_back(8'h5A);
    f0 = flash_low_cnt; r0 = ram_low_cnt;
    mem_we = 1'b0; mem_addr = 16'h0010; mem_req = 1'b1; t0 = cyc;
    run_until_acks(1'b0, 1'b1, 60);
    chk("read_latency", mem_ack_cyc - t0, 34);
    chk("read_flash_low", flash_low_cnt - f0, 0);
    chk("read_ram_low", ram_low_cnt - r0, 33);
    chk("fetch_rdata_kept", {24'd0, fetch_rdata}, 32'hA5);

    // Tie right after reset: data port first, then fetch in the IDLE after mem_ack
    reset = 1'b1; step(); reset = 1'b0; step();
    push_txn(8'h38, 16'h0020, 1'b1, 8'h77);
    push_txn(8'hEB, 16'h0100, 1'b0, 8'h00);
    slave_q.push_back(8'h11); exp_fetch_q.push_back(8'h11);
    mem_we = 1'b1; mem_addr = 16'h0020; mem_wdata = 8'h77;
    fetch_addr = 16'h0100;
    mem_req = 1'b1; fetch_req = 1'b1; t0 = cyc;
    run_until_acks(1'b1, 1'b1, 120);
    chk("tie1_mem_latency", mem_ack_cyc - t0, 22);
    chk("tie1_fetch_after_mem", fetch_ack_cyc - mem_ack_cyc, 35);

    // Second tie goes to fetch
    step();
    push_txn(8'hEB, 16'h0002, 1'b0, 8'h00);
    push_txn(8'hEB, 16'h0003, 1'b0, 8'h00);
    slave_q.push_back(8'hC3); slave_q.push_back(8'h96);
    exp_fetch_q.push_back(8'hC3); exp_mem_q.push_back(8'h96);
    mem_we = 1'b0; mem_addr = 16'h0003; fetch_addr = 16'h0002;
    mem_req = 1'b1; fetch_req = 1'b1; t0 = cyc;
    run_until_acks(1'b1, 1'b1, 120);
    chk("tie2_fetch_latency", fetch_ack_cyc - t0, 34);
    chk("tie2_mem_after_fetch", mem_ack_cyc - fetch_ack_cyc, 35);

    // Reset during the address phase of a fetch
    step();
    mon_check = 1'b0;
    a0 = fetch_ack_cnt;
    fetch_addr = 16'h5555; fetch_req = 1'b1;
    repeat (10) step();
    reset = 1'b1; fetch_req = 1'b0;
    step();
    chk("abort_flash_cs", {31'd0, spi_flash_select}, 32'd1);
    chk("abort_ram_cs", {31'd0, spi_ram_a_select}, 32'd1);
    chk("abort_oe", {28'd0, spi_data_oe}, 32'd0);
    chk("abort_clk", {31'd0, spi_clk_out}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_rdata", {16'd0, fetch_rdata, mem_rdata}, 32'd0);
    reset = 1'b0;
    repeat (4) step();
    chk("abort_no_ack", fetch_ack_cnt - a0, 0);
    mon_check = 1'b1;

    push_txn(8'hEB, 16'h0ABC, 1'b0, 8'h00);
    slave_q.push_back(8'h69); exp_fetch_q.push_back(8'h69);
    fetch_addr = 16'h0ABC; fetch_req = 1'b1; t0 = cyc;
    run_until_acks(1'b1, 1'b0, 60);
    chk("post_abort_latency", fetch_ack_cyc - t0, 34);

    // Address change after grant is ignored
    step();
    push_txn(8'hEB, 16'h4321, 1'b0, 8'h00);
    slave_q.push_back(8'h0F); exp_fetch_q.push_back(8'h0F);
    fetch_addr = 16'h4321; fetch_req = 1'b1; t0 = cyc;
    repeat (3) step();
    fetch_addr = 16'hFFFF;
    run_until_acks(1'b1, 1'b0, 60);
    chk("addr_change_latency", fetch_ack_cyc - t0, 34);

    repeat (3) step();
    chk("nibbles_drained", exp_q.size(), 0);
    chk("cycle_counts_drained", exp_cyc_q.size(), 0);
    chk("slave_bytes_drained", slave_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
